operand_issue: RTL

OPERAND_ISSUE -- requirements
Module: operand_issue

---
 rtl/rv32i_pkg.sv | 33 +++
 rtl/issue_scoreboard.sv | 56 +++++
 rtl/operand_issue.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// ----------------------------------------------------------------------------
// rv32i_pkg
// Shared decode constants and types for the RV32I operand issue stage.
//   - Major opcodes handled by the issue stage (OP, OP-IMM)
//   - funct3 encodings of the shift-immediate group (SLLI, SRLI/SRAI), the
//     only OP-IMM forms whose instr[31:25] carries a real funct7
//   - Output-stage state enumeration
//   - Immediate sign-extension helper
// ----------------------------------------------------------------------------
package rv32i_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

  localparam logic [6:0] F7_ZERO = 7'b0000000;

  // FULL and STALL both present a valid operation; STALL marks that the
  // consumer refused it at least once and the outputs are being held.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b01,
    ST_STALL = 2'b10
  } out_state_e;

  // Sign-extend a 12-bit I-type immediate to 32 bits.
  function automatic logic [31:0] sext12(input logic [11:0] imm);
    return {{20{imm[11]}}, imm};
  endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// ----------------------------------------------------------------------------
// issue_scoreboard
// Pending-write scoreboard: one bit per architectural register, set when an
// instruction writing that register issues, cleared when its writeback lands.
// Ports:
//   clock, reset_n      rising-edge clock, asynchronous active-low reset
//   set_en, set_idx     mark register set_idx as pending
//   clr_en, clr_idx     writeback of clr_idx completes this cycle
//   mask                registered pending mask (bit 0 always 0)
// ----------------------------------------------------------------------------
module issue_scoreboard
  import rv32i_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            set_en,
  input  logic [4:0]      set_idx,
  input  logic            clr_en,
  input  logic [4:0]      clr_idx,
  output logic [NREG-1:0] mask
);

  logic [NREG-1:0] mask_r;
  logic [NREG-1:0] mask_nxt_s;

  // Next mask: clear first, then set, so a same-cycle set on the same
  // register wins; x0 can never be pending.
  always_comb begin
    mask_nxt_s = mask_r;
    if (clr_en) begin
      mask_nxt_s[clr_idx] = 1'b0;
    end else begin
      mask_nxt_s = mask_r;
    end
    if (set_en) begin
      mask_nxt_s[set_idx] = 1'b1;
    end else begin
      mask_nxt_s[set_idx] = mask_nxt_s[set_idx];
    end
    mask_nxt_s[0] = 1'b0;
  end

  // Scoreboard state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mask_r <= {NREG{1'b0}};
    end else begin
      mask_r <= mask_nxt_s;
    end
  end

  assign mask = mask_r;

endmodule

// File: rtl/operand_issue.sv
// ----------------------------------------------------------------------------
// operand_issue
// RV32I operand-fetch / issue stage. Decodes OP and OP-IMM instructions,
// reads the register file, stalls on RAW hazards against a pending-write
// scoreboard and presents one registered ALU operation per cycle.
// Ports:
//   clock, reset_n            rising-edge clock, asynchronous active-low reset
//   instr_valid/instr/ready   upstream instruction handshake
//   rs1_addr, rs2_addr        register-file read addresses (combinational)
//   rs1_data, rs2_data        register-file read data (combinational)
//   wb_valid, wb_rd           writeback completion, clears pending bit
//   alu_enable/out_ready      downstream handshake
//   funct7, funct3            ALU operation select
//   register_data_1/_2        ALU operands
//   out_rd                    destination register of the issued operation
//   illegal                   one-cycle pulse when an unsupported opcode is taken
// ----------------------------------------------------------------------------
module operand_issue
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            instr_valid,
  input  logic [31:0]     instr,
  output logic            instr_ready,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  output logic            alu_enable,
  input  logic            out_ready,
  output logic [6:0]      funct7,
  output logic [2:0]      funct3,
  output logic [XLEN-1:0] register_data_1,
  output logic [XLEN-1:0] register_data_2,
  output logic [4:0]      out_rd,
  output logic            illegal
);

  out_state_e      state_r, state_nxt_s;
  logic [NREG-1:0] pending_s;
  logic            is_op_s, is_opimm_s, hazard_s, accept_s, issue_s;
  logic [4:0]      rd_s;
  logic [6:0]      f7_dec_s;
  logic [XLEN-1:0] op1_s, op2_s;

  logic            alu_enable_r, illegal_r;
  logic [6:0]      funct7_r;
  logic [2:0]      funct3_r;
  logic [XLEN-1:0] data1_r, data2_r;
  logic [4:0]      out_rd_r;

  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];
  assign rd_s     = instr[11:7];

  // Opcode decode, funct7 selection and operand muxing. x0 reads as zero
  // whatever the register file returns.
  always_comb begin
    is_op_s    = 1'b0;
    is_opimm_s = 1'b0;
    f7_dec_s   = F7_ZERO;
    op1_s      = (rs1_addr == 5'd0) ? {XLEN{1'b0}} : rs1_data;
    op2_s      = {XLEN{1'b0}};
    case (instr[6:0])
      OPC_OP: begin
        is_op_s  = 1'b1;
        f7_dec_s = instr[31:25];
        op2_s    = (rs2_addr == 5'd0) ? {XLEN{1'b0}} : rs2_data;
      end
      OPC_OP_IMM: begin
        is_opimm_s = 1'b1;
        op2_s      = sext12(instr[31:20]);
        // Only shifts carry a real funct7; ADDI etc. must never select SUB.
        if ((instr[14:12] == F3_SLL) || (instr[14:12] == F3_SR)) begin
          f7_dec_s = instr[31:25];
        end else begin
          f7_dec_s = F7_ZERO;
        end
      end
      default: begin
        is_op_s    = 1'b0;
        is_opimm_s = 1'b0;
      end
    endcase
  end

  // RAW hazard against the registered scoreboard; rs2 is a source only for OP,
  // and unsupported opcodes have no sources so they are never held back.
  assign hazard_s = instr_valid &
                    (((is_op_s | is_opimm_s) & pending_s[rs1_addr]) |
                     (is_op_s & pending_s[rs2_addr]));

  assign instr_ready = reset_n & ~hazard_s & ((state_r == ST_EMPTY) | out_ready);
  assign accept_s    = instr_valid & instr_ready;
  assign issue_s     = accept_s & (is_op_s | is_opimm_s);

  issue_scoreboard #(.NREG(NREG)) u_scoreboard (
    .clock   (clock),
    .reset_n (reset_n),
    .set_en  (issue_s & (rd_s != 5'd0)),
    .set_idx (rd_s),
    .clr_en  (wb_valid),
    .clr_idx (wb_rd),
    .mask    (pending_s)
  );

  // Output-stage next state: a new issue always refills; otherwise a taken
  // output drains and a refused one is held.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (issue_s) begin
          state_nxt_s = ST_FULL;
        end else begin
          state_nxt_s = ST_EMPTY;
        end
      end
      ST_FULL, ST_STALL: begin
        if (issue_s) begin
          state_nxt_s = ST_FULL;
        end else if (out_ready) begin
          state_nxt_s = ST_EMPTY;
        end else begin
          state_nxt_s = ST_STALL;
        end
      end
      default: begin
        state_nxt_s = ST_EMPTY;
      end
    endcase
  end

  // State register plus registered valid and illegal pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_EMPTY;
      alu_enable_r <= 1'b0;
      illegal_r    <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      alu_enable_r <= (state_nxt_s != ST_EMPTY);
      illegal_r    <= accept_s & ~is_op_s & ~is_opimm_s;
    end
  end

  // Output payload: loaded on issue, otherwise held so a stalled output stays stable.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      funct7_r <= 7'd0;
      funct3_r <= 3'd0;
      data1_r  <= {XLEN{1'b0}};
      data2_r  <= {XLEN{1'b0}};
      out_rd_r <= 5'd0;
    end else if (issue_s) begin
      funct7_r <= f7_dec_s;
      funct3_r <= instr[14:12];
      data1_r  <= op1_s;
      data2_r  <= op2_s;
      out_rd_r <= rd_s;
    end else begin
      funct7_r <= funct7_r;
      funct3_r <= funct3_r;
      data1_r  <= data1_r;
      data2_r  <= data2_r;
      out_rd_r <= out_rd_r;
    end
  end

  assign alu_enable      = alu_enable_r;
  assign illegal         = illegal_r;
  assign funct7          = funct7_r;
  assign funct3          = funct3_r;
  assign register_data_1 = data1_r;
  assign register_data_2 = data2_r;
  assign out_rd          = out_rd_r;

endmodule
